// File: rtl/game_pkg.sv
// Shared types and constants for the reaction game: FSM state codes, score width,
// winner codes, saturating score helpers and seven-segment digit patterns.
package game_pkg;

    localparam int SCORE_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_COUNTDOWN  = 3'd1,
        ST_GO         = 3'd2,
        ST_SCORE      = 3'd3,
        ST_MATCH_OVER = 3'd4
    } state_e;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    // Active-high segments ordered {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b000_0000;
    localparam logic [6:0] SEG_DASH  = 7'b100_0000;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = 7'b011_1111;
            4'd1:    seg = 7'b000_0110;
            4'd2:    seg = 7'b101_1011;
            4'd3:    seg = 7'b100_1111;
            4'd4:    seg = 7'b110_0110;
            4'd5:    seg = 7'b110_1101;
            4'd6:    seg = 7'b111_1101;
            4'd7:    seg = 7'b000_0111;
            4'd8:    seg = 7'b111_1111;
            4'd9:    seg = 7'b110_1111;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s,
                                                   input logic [SCORE_W-1:0] lim);
        return (s >= lim) ? s : s + 3'd1;
    endfunction

    function automatic logic [SCORE_W-1:0] sat_dec(input logic [SCORE_W-1:0] s);
        return (s == 3'd0) ? s : s - 3'd1;
    endfunction

endpackage

// File: rtl/round_timer.sv
// Loadable down counter that decrements on enabled cycles; flags count==0 and
// count==1 so the caller can act on the tick that reaches zero.
module round_timer #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o,
    output logic         last_o
);

    logic [W-1:0] count_q;

    // Load has priority over the tick-gated decrement; zero holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end else begin
            count_q <= count_q;
        end
    end

    assign zero_o = (count_q == '0);
    assign last_o = (count_q == W'(1));

endmodule

// File: rtl/round_arbiter.sv
// Two-player reaction game arbiter: countdown, GO window, scoring to WIN_SCORE.
// Define FALSE_START_PENALTY_EN to penalise presses made during the countdown.
module round_arbiter
    import game_pkg::*;
#(
    parameter int COUNT_MS  = 50,
    parameter int REACT_MS  = 2000,
    parameter int WIN_SCORE = 5
) (
    input  logic               cin,
    input  logic               reset_n,
    input  logic               tick,
    input  logic               start,
    input  logic               p1_btn,
    input  logic               p2_btn,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic               go_led,
    output logic               busy,
    output logic [1:0]         winner,
    output logic [2:0]         state
);

    localparam int MAX_CNT = (COUNT_MS > REACT_MS) ? COUNT_MS : REACT_MS;
    localparam int CNT_W   = (MAX_CNT < 1) ? 1 : $clog2(MAX_CNT + 1);
    localparam logic [SCORE_W-1:0] WIN_S = SCORE_W'(WIN_SCORE);

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] p1_score_q, p1_score_d;
    logic [SCORE_W-1:0] p2_score_q, p2_score_d;
    logic [1:0]         winner_q, winner_d;
    logic               go_led_q, busy_q;
    logic               start_q, p1_q, p2_q, arm_q;
    logic               start_edge_s, p1_edge_s, p2_edge_s;
    logic               tmr_en_s, tmr_load_s, tmr_zero_s, tmr_last_s, expire_s;
    logic [CNT_W-1:0]   tmr_val_s;

    // Previous-value registers; arm_q masks edges on the first cycle after reset.
    always_ff @(posedge cin) begin
        if (!reset_n) begin
            start_q <= 1'b0;
            p1_q    <= 1'b0;
            p2_q    <= 1'b0;
            arm_q   <= 1'b0;
        end else begin
            start_q <= start;
            p1_q    <= p1_btn;
            p2_q    <= p2_btn;
            arm_q   <= 1'b1;
        end
    end

    assign start_edge_s = start  & ~start_q & arm_q;
    assign p1_edge_s    = p1_btn & ~p1_q    & arm_q;
    assign p2_edge_s    = p2_btn & ~p2_q    & arm_q;

    assign tmr_en_s = tick & ((state_q == ST_COUNTDOWN) || (state_q == ST_GO));
    assign expire_s = tmr_en_s & (tmr_zero_s | tmr_last_s);

    round_timer #(.W(CNT_W)) u_timer (
        .clk        (cin),
        .rst_n      (reset_n),
        .en_i       (tmr_en_s),
        .load_i     (tmr_load_s),
        .load_val_i (tmr_val_s),
        .zero_o     (tmr_zero_s),
        .last_o     (tmr_last_s)
    );

    // Next-state, score and timer-load decisions.
    always_comb begin
        state_d    = state_q;
        p1_score_d = p1_score_q;
        p2_score_d = p2_score_q;
        winner_d   = winner_q;
        tmr_load_s = 1'b0;
        tmr_val_s  = '0;
        case (state_q)
            ST_IDLE: begin
                if (start_edge_s) begin
                    state_d    = ST_COUNTDOWN;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = CNT_W'(COUNT_MS);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COUNTDOWN: begin
`ifdef FALSE_START_PENALTY_EN
                if (p1_edge_s || p2_edge_s) begin
                    p1_score_d = p1_edge_s ? sat_dec(p1_score_q) : p1_score_q;
                    p2_score_d = p2_edge_s ? sat_dec(p2_score_q) : p2_score_q;
                    state_d    = ST_IDLE;
                end else if (expire_s) begin
                    state_d    = ST_GO;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = CNT_W'(REACT_MS);
                end else begin
                    state_d = ST_COUNTDOWN;
                end
`else
                if (expire_s) begin
                    state_d    = ST_GO;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = CNT_W'(REACT_MS);
                end else begin
                    state_d = ST_COUNTDOWN;
                end
`endif
            end
            ST_GO: begin
                // A press on the final tick still counts: presses beat timeout.
                if (p1_edge_s && p2_edge_s) begin
                    state_d = ST_SCORE;
                end else if (p1_edge_s) begin
                    p1_score_d = sat_inc(p1_score_q, WIN_S);
                    state_d    = ST_SCORE;
                end else if (p2_edge_s) begin
                    p2_score_d = sat_inc(p2_score_q, WIN_S);
                    state_d    = ST_SCORE;
                end else if (expire_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GO;
                end
            end
            ST_SCORE: begin
                if ((p1_score_q == WIN_S) || (p2_score_q == WIN_S)) begin
                    state_d  = ST_MATCH_OVER;
                    winner_d = (p1_score_q == WIN_S) ? WIN_P1 : WIN_P2;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MATCH_OVER: begin
                state_d = ST_MATCH_OVER;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; go_led/busy decoded from the next state.
    always_ff @(posedge cin) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            p1_score_q <= '0;
            p2_score_q <= '0;
            winner_q   <= WIN_NONE;
            go_led_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            p1_score_q <= p1_score_d;
            p2_score_q <= p2_score_d;
            winner_q   <= winner_d;
            go_led_q   <= (state_d == ST_GO);
            busy_q     <= (state_d == ST_COUNTDOWN) || (state_d == ST_GO) ||
                          (state_d == ST_SCORE);
        end
    end

    assign p1_score = p1_score_q;
    assign p2_score = p2_score_q;
    assign go_led   = go_led_q;
    assign busy     = busy_q;
    assign winner   = winner_q;
    assign state    = state_q;

endmodule

// File: tb/tb_round_arbiter.sv
// Directed bench for round_arbiter with COUNT_MS=3, REACT_MS=4, WIN_SCORE=5;
// the countdown-press scenario follows FALSE_START_PENALTY_EN.
module tb_round_arbiter;

    logic       cin = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       p1_btn = 1'b0;
    logic       p2_btn = 1'b0;
    logic [2:0] p1_score, p2_score;
    logic       go_led, busy;
    logic [1:0] winner;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    round_arbiter #(.COUNT_MS(3), .REACT_MS(4), .WIN_SCORE(5)) dut (
        .cin      (cin),
        .reset_n  (reset_n),
        .tick     (tick),
        .start    (start),
        .p1_btn   (p1_btn),
        .p2_btn   (p2_btn),
        .p1_score (p1_score),
        .p2_score (p2_score),
        .go_led   (go_led),
        .busy     (busy),
        .winner   (winner),
        .state    (state)
    );

    always #5 cin = ~cin;

    task automatic cyc();
        @(posedge cin);
        #1;
    endtask

    task automatic to_go();
        start = 1'b1;
        cyc();
        start = 1'b0;
        tick = 1'b1;
        repeat (3) cyc();
        tick = 1'b0;
    endtask

    task automatic press(input logic a, input logic b);
        p1_btn = a;
        p2_btn = b;
        cyc();
        p1_btn = 1'b0;
        p2_btn = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cyc();
        cyc();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", state); end
        checks++; if (p1_score !== 3'd0 || p2_score !== 3'd0) begin errors++; $display("FAIL rst_scores got=%0d/%0d exp=0/0", p1_score, p2_score); end
        checks++; if (winner !== 2'b00) begin errors++; $display("FAIL rst_winner got=%b exp=00", winner); end
        checks++; if (go_led !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_flags go=%b busy=%b exp=0/0", go_led, busy); end
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_round_p1();
        start = 1'b1;
        cyc();
        start = 1'b0;
        checks++; if (state !== 3'd1 || busy !== 1'b1) begin errors++; $display("FAIL cd_enter state=%0d busy=%b exp=1/1", state, busy); end
        tick = 1'b1;
        cyc();
        cyc();
        checks++; if (state !== 3'd1 || go_led !== 1'b0) begin errors++; $display("FAIL cd_two_ticks state=%0d go=%b exp=1/0", state, go_led); end
        cyc();
        tick = 1'b0;
        checks++; if (state !== 3'd2 || go_led !== 1'b1) begin errors++; $display("FAIL go_enter state=%0d go=%b exp=2/1", state, go_led); end
        p1_btn = 1'b1;
        cyc();
        p1_btn = 1'b0;
        checks++; if (p1_score !== 3'd1 || state !== 3'd3) begin errors++; $display("FAIL p1_point score=%0d state=%0d exp=1/3", p1_score, state); end
        checks++; if (go_led !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL score_flags go=%b busy=%b exp=0/1", go_led, busy); end
        cyc();
        checks++; if (state !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL back_idle state=%0d busy=%b exp=0/0", state, busy); end
    endtask

    task automatic test_tie();
        to_go();
        p1_btn = 1'b1;
        p2_btn = 1'b1;
        cyc();
        p1_btn = 1'b0;
        p2_btn = 1'b0;
        checks++; if (state !== 3'd3 || p1_score !== 3'd1 || p2_score !== 3'd0) begin errors++; $display("FAIL tie state=%0d p1=%0d p2=%0d exp=3/1/0", state, p1_score, p2_score); end
        cyc();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL tie_idle state=%0d exp=0", state); end
    endtask

    task automatic test_timeout();
        to_go();
        tick = 1'b1;
        repeat (3) cyc();
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL go_three_ticks state=%0d exp=2", state); end
        cyc();
        tick = 1'b0;
        checks++; if (state !== 3'd0 || go_led !== 1'b0) begin errors++; $display("FAIL timeout state=%0d go=%b exp=0/0", state, go_led); end
        checks++; if (p1_score !== 3'd1 || p2_score !== 3'd0) begin errors++; $display("FAIL timeout_scores p1=%0d p2=%0d exp=1/0", p1_score, p2_score); end
    endtask

    task automatic test_start_while_busy();
        start = 1'b1;
        cyc();
        start = 1'b0;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        tick = 1'b1;
        cyc();
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL busy_start_cd state=%0d exp=1", state); end
        cyc();
        tick = 1'b0;
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL busy_start_no_reload state=%0d exp=2", state); end
        press(1'b0, 1'b1);
        checks++; if (p2_score !== 3'd1 || state !== 3'd0) begin errors++; $display("FAIL p2_point p2=%0d state=%0d exp=1/0", p2_score, state); end
    endtask

    task automatic test_countdown_press();
`ifdef FALSE_START_PENALTY_EN
        to_go();
        press(1'b1, 1'b0);
        checks++; if (p1_score !== 3'd2) begin errors++; $display("FAIL pen_setup p1=%0d exp=2", p1_score); end
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            cyc();
            start = 1'b0;
            p1_btn = 1'b1;
            cyc();
            p1_btn = 1'b0;
            checks++; if (state !== 3'd0 || p1_score !== ((i == 0) ? 3'd1 : 3'd0)) begin errors++; $display("FAIL penalty_%0d state=%0d p1=%0d exp=0/%0d", i, state, p1_score, (i == 0) ? 1 : 0); end
            cyc();
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        p1_btn = 1'b1;
        p2_btn = 1'b1;
        cyc();
        p1_btn = 1'b0;
        p2_btn = 1'b0;
        checks++; if (state !== 3'd0 || p1_score !== 3'd0 || p2_score !== 3'd0) begin errors++; $display("FAIL penalty_both state=%0d p1=%0d p2=%0d exp=0/0/0", state, p1_score, p2_score); end
`else
        start = 1'b1;
        cyc();
        start = 1'b0;
        p1_btn = 1'b1;
        cyc();
        p1_btn = 1'b0;
        checks++; if (state !== 3'd1 || p1_score !== 3'd1) begin errors++; $display("FAIL cd_press_ignored state=%0d p1=%0d exp=1/1", state, p1_score); end
        tick = 1'b1;
        repeat (3) cyc();
        tick = 1'b0;
        checks++; if (state !== 3'd2 || go_led !== 1'b1) begin errors++; $display("FAIL cd_press_go state=%0d go=%b exp=2/1", state, go_led); end
        tick = 1'b1;
        repeat (4) cyc();
        tick = 1'b0;
        checks++; if (state !== 3'd0 || p1_score !== 3'd1) begin errors++; $display("FAIL cd_press_timeout state=%0d p1=%0d exp=0/1", state, p1_score); end
`endif
    endtask

    task automatic test_reset_held();
        to_go();
        p1_btn = 1'b1;
        reset_n = 1'b0;
        cyc();
        checks++; if (state !== 3'd0 || p1_score !== 3'd0 || go_led !== 1'b0) begin errors++; $display("FAIL mid_go_reset state=%0d p1=%0d go=%b exp=0/0/0", state, p1_score, go_led); end
        reset_n = 1'b1;
        cyc();
        to_go();
        cyc();
        checks++; if (state !== 3'd2 || p1_score !== 3'd0) begin errors++; $display("FAIL held_no_edge state=%0d p1=%0d exp=2/0", state, p1_score); end
        p1_btn = 1'b0;
        cyc();
        p1_btn = 1'b1;
        cyc();
        p1_btn = 1'b0;
        checks++; if (state !== 3'd3 || p1_score !== 3'd1) begin errors++; $display("FAIL held_repress state=%0d p1=%0d exp=3/1", state, p1_score); end
        cyc();
    endtask

    task automatic test_match();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        cyc();
        repeat (4) begin
            to_go();
            press(1'b0, 1'b1);
        end
        checks++; if (state !== 3'd0 || p2_score !== 3'd4 || winner !== 2'b00) begin errors++; $display("FAIL four_wins state=%0d p2=%0d win=%b exp=0/4/00", state, p2_score, winner); end
        to_go();
        p2_btn = 1'b1;
        cyc();
        p2_btn = 1'b0;
        checks++; if (state !== 3'd3 || p2_score !== 3'd5) begin errors++; $display("FAIL fifth_win state=%0d p2=%0d exp=3/5", state, p2_score); end
        cyc();
        checks++; if (state !== 3'd4 || winner !== 2'b10 || busy !== 1'b0) begin errors++; $display("FAIL match_over state=%0d win=%b busy=%b exp=4/10/0", state, winner, busy); end
        to_go();
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        checks++; if (state !== 3'd4 || winner !== 2'b10 || p1_score !== 3'd0 || p2_score !== 3'd5) begin errors++; $display("FAIL match_hold state=%0d win=%b p1=%0d p2=%0d exp=4/10/0/5", state, winner, p1_score, p2_score); end
        checks++; if (go_led !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL match_flags go=%b busy=%b exp=0/0", go_led, busy); end
        reset_n = 1'b0;
        cyc();
        checks++; if (state !== 3'd0 || winner !== 2'b00 || p1_score !== 3'd0 || p2_score !== 3'd0) begin errors++; $display("FAIL match_reset state=%0d win=%b p1=%0d p2=%0d exp=0/00/0/0", state, winner, p1_score, p2_score); end
        reset_n = 1'b1;
        cyc();
    endtask

    initial begin
        test_reset();
        test_round_p1();
        test_tie();
        test_timeout();
        test_start_while_busy();
        test_countdown_press();
        test_reset_held();
        test_match();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/round_arbiter.md
ROUND_ARBITER -- requirements
Module: round_arbiter

Interface
REQ-001 SHALL have parameter COUNT_MS, default 50, meaning countdown length in ticks before the GO window opens.
REQ-002 SHALL have parameter REACT_MS, default 2000, meaning GO window length in ticks before the round times out.
REQ-003 SHALL have parameter WIN_SCORE, default 5, meaning score that ends the match (range 1..7).
REQ-004 SHALL have ports: cin in 1 system clock; reset_n in 1 synchronous active-low reset, sampled on rising cin.
REQ-005 SHALL have ports: tick in 1 one-cycle 1 ms enable; start in 1 level request to begin a round.
REQ-006 SHALL have ports: p1_btn in 1 and p2_btn in 1, debounced player levels.
REQ-007 SHALL have ports: p1_score out 3 and p2_score out 3, player scores.
REQ-008 SHALL have ports: go_led out 1 (GO window open), busy out 1 (round in progress), winner out 2 (00 none, 01 P1, 10 P2), state out 3 (FSM state code).

Function
REQ-009 SHALL detect rising edges of start, p1_btn and p2_btn internally with one registered previous value each; only edges act.
REQ-010 SHALL implement states IDLE, COUNTDOWN, GO, SCORE, MATCH_OVER, encoded 0..4 on state.
REQ-011 IDLE: on start edge SHALL load countdown counter with COUNT_MS and enter COUNTDOWN next cycle.
REQ-012 COUNTDOWN: SHALL decrement the counter only on cycles with tick=1; on reaching 0 SHALL load REACT_MS and enter GO.
REQ-013 GO: go_led SHALL be 1 exactly while in GO; first player edge SHALL add 1 to that player's score and enter SCORE.
REQ-014 GO: p1 and p2 edges in the same cycle SHALL award no point and enter SCORE (tie).
REQ-015 GO: counter reaching 0 with no press SHALL enter IDLE with no score change.
REQ-016 SCORE: SHALL last exactly one cycle; if either score equals WIN_SCORE, enter MATCH_OVER and set winner, else enter IDLE.
REQ-017 MATCH_OVER: SHALL ignore all button and start edges and hold scores and winner until reset.
REQ-018 busy SHALL be 1 in COUNTDOWN, GO and SCORE, 0 otherwise.
REQ-019 Scores SHALL saturate at WIN_SCORE and at 0; no wrap-around.
REQ-020 start edges while busy SHALL be ignored.
REQ-021 Latency from qualifying press edge to score update SHALL be one cycle.

Reset
REQ-022 reset_n=0 at a rising cin SHALL force IDLE, scores 0, winner 00, go_led 0, busy 0, counter 0, edge registers 0, regardless of current state.
REQ-023 A button held through reset release SHALL NOT produce an edge (edge registers load the inputs' current values on the first cycle after reset).

Configuration
REQ-024 Macro FALSE_START_PENALTY_EN defined: a player edge in COUNTDOWN SHALL decrement that player's score (saturating at 0) and return to IDLE; simultaneous edges SHALL penalise both.
REQ-025 Macro FALSE_START_PENALTY_EN undefined: player edges in COUNTDOWN SHALL be ignored and the countdown continues.

Structure
REQ-026 Package game_pkg SHALL hold the state enum, SCORE_W=3, winner codes, and seven-segment constants shared with the display logic.
REQ-027 Sub-module round_timer (loadable tick-enabled down counter with zero flag) SHALL implement the COUNTDOWN/GO counter.

Verification
REQ-028 COUNT_MS=3: start edge, 3 ticks, p1 edge -> go_led high after 3rd tick; p1_score 0->1 one cycle after edge; state IDLE.
REQ-029 In GO, p1 and p2 edges in the same cycle -> both scores unchanged, state SCORE then IDLE.
REQ-030 REACT_MS=4, no press for 4 ticks in GO -> IDLE, scores unchanged, go_led 0.
REQ-031 p2 wins 5 rounds -> winner=10, state MATCH_OVER; further start and button edges change nothing; reset_n low -> all zero.
REQ-032 With FALSE_START_PENALTY_EN, p1_score=2, p1 edge in COUNTDOWN -> p1_score=1, IDLE; repeat at score 0 -> stays 0; without the macro the same stimulus -> countdown completes, GO reached.
REQ-033 reset_n asserted mid-GO with p1_btn held high -> IDLE; after release no score until p1_btn falls and rises again.
